semafor_ctrl: RTL
=================

# semafor_ctrl

Traffic-light controller downstream of the UART receiver (`uart`). It consumes the 2-bit mode word the receiver presents on `rx_data` and filters it for stability. It then drives the red/yellow/green lamps of one signal head through a timed normal cycle, a night (yellow-blink) mode, an all-red emergency mode, or dark. All lamp outputs are registered.

## Interface
Parameters:
- `STABLE_CYCLES`, 16: consecutive identical samples of `mode_in` required before a mode is accepted (≥1).
- `T_RED`, 500: cycles in RED.
- `T_RY`, 100: cycles in RED_YELLOW.
- `T_GREEN`, 500: cycles in GREEN.
- `T_GBLINK`, 160: cycles in GREEN_BLINK.
- `T_YELLOW`, 100: cycles in YELLOW.
- `BLINK_HALF`, 20: half-period of every blink, in cycles (≥1).
- `CNT_W`, 16: phase counter width. It must hold `max(T_*)-1`.

Ports:
- `rxclk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `mode_in`, in, 2: mode word from `uart.rx_data`.
- `red`, out, 1: red lamp.
- `yellow`, out, 1: yellow lamp.
- `green`, out, 1: green lamp.
- `mode_q`, out, 2: currently accepted mode.

## Operation
- Mode encoding:
  - 00: OFF, all lamps dark.
  - 01: NORMAL.
  - 10: NIGHT, yellow blinks.
  - 11: ALLRED, red steady.
- Stability filter:
  - `cand` register holds the last sample; `stab_cnt` counts consecutive edges where `mode_in == cand`.
  - A differing sample loads `cand` and clears `stab_cnt` to 0.
  - On the edge where `stab_cnt` would reach `STABLE_CYCLES-1` with `cand != mode_q`, `mode_q <= cand`.
  - A glitch shorter than `STABLE_CYCLES` never changes `mode_q`.
- NORMAL sequence, looping: RED(r) → RED_YELLOW(r+y) → GREEN(g) → GREEN_BLINK(g toggling) → YELLOW(y) → RED.
  - Each phase lasts exactly its `T_*` cycles. The phase counter loads `T_*-1` on entry, decrements each cycle, and transitions on 0.
- Blink generator:
  - Counter plus phase bit; the phase toggles every `BLINK_HALF` cycles.
  - It restarts with the lamp ON on entry to GREEN_BLINK and on acceptance of NIGHT.
- Mode changes act immediately on acceptance, mid-phase included:
  - Leaving NORMAL abandons the phase.
  - Entering NORMAL always starts at RED with a full `T_RED`.
  - Re-acceptance of the current mode is impossible, because the filter requires `cand != mode_q`.
- Unused states recover to RED on the next edge.

## Timing
- Reset values:
  - `mode_q`=2'b11 (ALLRED), `cand`=2'b11, `stab_cnt`=0.
  - State RED, phase and blink counters 0.
  - Outputs `red`=1, `yellow`=0, `green`=0.
- Reset asserted mid-operation overrides everything on that edge and returns to the reset values.
- Latency: if `mode_in` presents a new value steadily from edge k, `mode_q` updates at edge k+STABLE_CYCLES-1. Lamps reflect the new mode at edge k+STABLE_CYCLES.
- Lamps are registered and follow state/mode one edge late. There are no combinational paths from `mode_in` to the lamps.
- A mode acceptance and a phase expiry on the same edge: the mode acceptance wins.
- Only one lamp pattern per state; red+green is never simultaneously 1.

## Structure
- `semafor_pkg`:
  - Mode encodings `MODE_OFF/NORMAL/NIGHT/ALLRED`.
  - Phase state enum `S_RED, S_RY, S_GREEN, S_GBLINK, S_YELLOW`.
  - Lamp vector typedef `{red,yellow,green}`.
- Sub-module `mode_filter`: the `cand`/`stab_cnt` logic. It is parameterised by `STABLE_CYCLES` and outputs `mode_q`.
- Top-level `semafor_ctrl` holds the phase FSM, phase counter, blink generator and lamp output registers.

## Test plan
Bench parameters: `STABLE_CYCLES`=4, `T_RED`=10, `T_RY`=3, `T_GREEN`=10, `T_GBLINK`=8, `T_YELLOW`=3, `BLINK_HALF`=2; clock period 20 ns.
- Reset held 3 cycles, `mode_in`=11 → lamps r=1 y=0 g=0 and `mode_q`=11 throughout and after release.
- `mode_in`=01 from edge k → `mode_q`=01 at k+3.
  - Red 10 cycles, then r+y 3, green 10.
  - Green 1,1,0,0,1,1,0,0 over 8 cycles, then yellow 3, then red again.
- NORMAL running, `mode_in` pulses 10 for 3 cycles, then returns to 01 → `mode_q` stays 01 and the sequence is uninterrupted.
- NORMAL in GREEN, `mode_in`=10 held → after 4 samples `mode_q`=10 and green drops; yellow pattern 1,1,0,0 repeating with r=g=0.
- NIGHT, then `mode_in`=00 held → all lamps 0 after the filter delay. Then `mode_in`=01 → starts at RED with a full 10 cycles.
- NORMAL mid-GREEN, `reset`=1 for 1 cycle → next edge r=1 y=0 g=0 and `mode_q`=11. With `mode_in`=01 still held, NORMAL re-accepted 4 cycles after reset release.

Source files
------------

// File: rtl/semafor_pkg.sv
// Shared encodings for the traffic-light controller: mode words, phase states
// and the registered lamp vector.
package semafor_pkg;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_NORMAL = 2'b01;
  localparam logic [1:0] MODE_NIGHT  = 2'b10;
  localparam logic [1:0] MODE_ALLRED = 2'b11;

  typedef enum logic [2:0] {
    S_RED    = 3'd0,
    S_RY     = 3'd1,
    S_GREEN  = 3'd2,
    S_GBLINK = 3'd3,
    S_YELLOW = 3'd4
  } phase_e;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamps_t;

  localparam lamps_t LAMPS_DARK   = 3'b000;
  localparam lamps_t LAMPS_RED    = 3'b100;
  localparam lamps_t LAMPS_RY     = 3'b110;
  localparam lamps_t LAMPS_YELLOW = 3'b010;
  localparam lamps_t LAMPS_GREEN  = 3'b001;

  // One lamp pattern per (mode, phase); unknown phases fall back to red.
  function automatic lamps_t lamps_for(input logic [1:0] mode,
                                       input phase_e     st,
                                       input logic       blink);
    lamps_t l;
    l = LAMPS_DARK;
    case (mode)
      MODE_OFF:    l = LAMPS_DARK;
      MODE_NIGHT:  l = blink ? LAMPS_YELLOW : LAMPS_DARK;
      MODE_ALLRED: l = LAMPS_RED;
      default: begin
        case (st)
          S_RED:    l = LAMPS_RED;
          S_RY:     l = LAMPS_RY;
          S_GREEN:  l = LAMPS_GREEN;
          S_GBLINK: l = blink ? LAMPS_GREEN : LAMPS_DARK;
          S_YELLOW: l = LAMPS_YELLOW;
          default:  l = LAMPS_RED;
        endcase
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/semafor_ctrl_mode_filter.sv
// Stability filter for the incoming mode word: a new mode is accepted only
// after STABLE_CYCLES identical consecutive samples that differ from the current one.
module mode_filter
  import semafor_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] mode_i,
  output logic [1:0] mode_o,
  output logic       accept_o
);

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);

  logic [1:0]    cand_q, cand_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [1:0]    mode_q, mode_d;
  logic          accept;

  // stab_cnt saturates so a long steady input never wraps into a false count.
  always_comb begin
    cand_d = mode_i;
    if (mode_i != cand_q) begin
      stab_d = '0;
    end else if (stab_q == STAB_MAX) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + 1'b1;
    end
    accept = (stab_d == STAB_MAX) && (mode_i != mode_q);
    mode_d = accept ? mode_i : mode_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cand_q <= MODE_ALLRED;
      stab_q <= '0;
      mode_q <= MODE_ALLRED;
    end else begin
      cand_q <= cand_d;
      stab_q <= stab_d;
      mode_q <= mode_d;
    end
  end

  assign mode_o   = mode_q;
  assign accept_o = accept;

endmodule

// File: rtl/semafor_ctrl.sv
// Traffic-light head controller: filtered mode select, timed NORMAL phase
// sequence, blink generator and registered lamp outputs.
//
// state    | meaning
// S_RED    | red steady, T_RED cycles
// S_RY     | red + yellow, T_RY cycles
// S_GREEN  | green steady, T_GREEN cycles
// S_GBLINK | green blinking, T_GBLINK cycles
// S_YELLOW | yellow steady, T_YELLOW cycles, then back to S_RED
module semafor_ctrl
  import semafor_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int T_RED         = 500,
  parameter int T_RY          = 100,
  parameter int T_GREEN       = 500,
  parameter int T_GBLINK      = 160,
  parameter int T_YELLOW      = 100,
  parameter int BLINK_HALF    = 20,
  parameter int CNT_W         = 16
) (
  input  logic       rxclk,
  input  logic       reset,
  input  logic [1:0] mode_in,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic [1:0] mode_q
);

  localparam logic [CNT_W-1:0] LD_RED    = CNT_W'(T_RED - 1);
  localparam logic [CNT_W-1:0] LD_RY     = CNT_W'(T_RY - 1);
  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_GBLINK = CNT_W'(T_GBLINK - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BL_LD = BW'(BLINK_HALF - 1);

  logic             accept;
  logic [1:0]       mode_cur;

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             blink_q, blink_d;
  lamps_t           lamps_q, lamps_d;

  phase_e           nxt_state;
  logic [CNT_W-1:0] nxt_load;
  logic             state_valid;
  logic             advance;
  logic             blink_restart;

  mode_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk_i   (rxclk),
    .reset_i (reset),
    .mode_i  (mode_in),
    .mode_o  (mode_cur),
    .accept_o(accept)
  );

  // Successor phase and its counter preload.
  always_comb begin
    nxt_state   = S_RED;
    nxt_load    = LD_RED;
    state_valid = 1'b1;
    case (state_q)
      S_RED: begin
        nxt_state = S_RY;
        nxt_load  = LD_RY;
      end
      S_RY: begin
        nxt_state = S_GREEN;
        nxt_load  = LD_GREEN;
      end
      S_GREEN: begin
        nxt_state = S_GBLINK;
        nxt_load  = LD_GBLINK;
      end
      S_GBLINK: begin
        nxt_state = S_YELLOW;
        nxt_load  = LD_YELLOW;
      end
      S_YELLOW: begin
        nxt_state = S_RED;
        nxt_load  = LD_RED;
      end
      default: state_valid = 1'b0;
    endcase
  end

  // A mode acceptance takes priority over any phase expiry on the same edge;
  // the phase sequence is frozen whenever the accepted mode is not NORMAL.
  assign advance = (mode_cur == MODE_NORMAL) && !accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept && (mode_in == MODE_NORMAL)) begin
      state_d = S_RED;
      cnt_d   = LD_RED;
    end else if (!state_valid) begin
      state_d = S_RED;
      cnt_d   = LD_RED;
    end else if (advance) begin
      if (cnt_q == '0) begin
        state_d = nxt_state;
        cnt_d   = nxt_load;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  assign blink_restart = ((state_d == S_GBLINK) && (state_q != S_GBLINK)) ||
                         (accept && (mode_in == MODE_NIGHT));

  always_comb begin
    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if (blink_restart) begin
      blink_d = 1'b1;
      bcnt_d  = BL_LD;
    end else if (bcnt_q == '0) begin
      blink_d = ~blink_q;
      bcnt_d  = BL_LD;
    end else begin
      bcnt_d = bcnt_q - 1'b1;
    end
  end

  assign lamps_d = lamps_for(mode_cur, state_q, blink_q);

  always_ff @(posedge rxclk) begin
    if (reset) begin
      state_q <= S_RED;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      lamps_q <= LAMPS_RED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      lamps_q <= lamps_d;
    end
  end

  assign red    = lamps_q.red;
  assign yellow = lamps_q.yellow;
  assign green  = lamps_q.green;
  assign mode_q = mode_cur;

endmodule
